// File: rtl/irq_conditioner.sv
// Interrupt conditioning ahead of the core wrapper: per-lane sync + glitch filter
// for async lines, sticky IPI pending with coalesce counter, reset-masked outputs.

module irq_cond_lane #(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);
  logic [SyncStages-1:0] sync_q;
  logic [7:0]            cnt_q;
  logic                  s;

  assign s = sync_q[SyncStages-1];

  // Filter counts consecutive cycles where s disagrees with the held level;
  // any agreement restarts the count so short pulses never get through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], async_i};
      if (s == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(FilterCycles - 1)) begin
        level_o <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
endmodule

module irq_conditioner #(
  parameter int unsigned NrIrq        = 2,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned CntWidth     = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                core_rst_ni,
  input  logic [NrIrq-1:0]    irq_async_i,
  input  logic                time_irq_async_i,
  input  logic                debug_req_async_i,
  input  logic                ipi_set_i,
  input  logic                ipi_clr_i,
  output logic [NrIrq-1:0]    irq_o,
  output logic                time_irq_o,
  output logic                debug_req_o,
  output logic                ipi_o,
  output logic [CntWidth-1:0] ipi_cnt_o
);
  localparam int unsigned NUM_LANES = NrIrq + 2;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] lvl;
  logic                 ipi_p;
  logic [CntWidth-1:0]  ipi_c;

  // Lane order: ext irqs low, then timer, then debug on top.
  assign raw = {debug_req_async_i, time_irq_async_i, irq_async_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    irq_cond_lane #(
      .SyncStages  (SyncStages),
      .FilterCycles(FilterCycles)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .async_i(raw[g]),
      .level_o(lvl[g])
    );
  end

  // Set beats clear; a set arriving on an already-pending IPI is coalesced.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ipi_p <= 1'b0;
      ipi_c <= '0;
    end else if (ipi_set_i) begin
      ipi_p <= 1'b1;
      if (ipi_clr_i)            ipi_c <= '0;
      else if (ipi_p && ~&ipi_c) ipi_c <= ipi_c + 1'b1;
    end else if (ipi_clr_i) begin
      ipi_p <= 1'b0;
      ipi_c <= '0;
    end
  end

  // Only the outputs are gated by core reset; state above keeps running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o       <= '0;
      time_irq_o  <= 1'b0;
      debug_req_o <= 1'b0;
      ipi_o       <= 1'b0;
      ipi_cnt_o   <= '0;
    end else begin
      irq_o       <= core_rst_ni ? lvl[NrIrq-1:0] : '0;
      time_irq_o  <= core_rst_ni & lvl[NrIrq];
      debug_req_o <= core_rst_ni & lvl[NrIrq+1];
      ipi_o       <= core_rst_ni & ipi_p;
      ipi_cnt_o   <= core_rst_ni ? ipi_c : '0;
    end
  end
endmodule

// File: tb/tb_irq_conditioner.sv
// Bench for irq_conditioner: IPI vector table, hand-written corner sequences,
// and random stimulus checked every cycle against a history-based reference model.

module tb_irq_conditioner;
  localparam int NR = 2;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int CW = 4;
  localparam int NL = NR + 2;
  localparam logic [CW-1:0] MAXC = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_n;
  logic [NR-1:0] irq_a;
  logic          time_a, dbg_a, set_i, clr_i;
  logic [NR-1:0] irq_o;
  logic          time_irq_o, debug_req_o, ipi_o;
  logic [CW-1:0] ipi_cnt_o;

  irq_conditioner #(.NrIrq(NR), .SyncStages(SS), .FilterCycles(FC), .CntWidth(CW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .core_rst_ni      (core_n),
    .irq_async_i      (irq_a),
    .time_irq_async_i (time_a),
    .debug_req_async_i(dbg_a),
    .ipi_set_i        (set_i),
    .ipi_clr_i        (clr_i),
    .irq_o            (irq_o),
    .time_irq_o       (time_irq_o),
    .debug_req_o      (debug_req_o),
    .ipi_o            (ipi_o),
    .ipi_cnt_o        (ipi_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw input history (hist[d] = inputs sampled d edges ago).
  // A lane flips once the last FC filter-visible samples all disagree with it.
  logic [NL-1:0] hist[$];
  logic [NL-1:0] m_f;
  logic          m_p;
  logic [CW-1:0] m_c;
  logic [NR-1:0] exp_irq;
  logic          exp_time, exp_dbg, exp_ipi;
  logic [CW-1:0] exp_cnt;

  typedef struct {
    logic          set;
    logic          clr;
    logic          exp_ipi;
    logic [CW-1:0] exp_cnt;
  } ipi_vec_t;
  ipi_vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    m_f = '0; m_p = 1'b0; m_c = '0;
    exp_irq = '0; exp_time = 1'b0; exp_dbg = 1'b0; exp_ipi = 1'b0; exp_cnt = '0;
  endtask

  task automatic model_edge();
    logic [NL-1:0] a, h, flip;
    a = {dbg_a, time_a, irq_a};
    hist.push_front(a);
    if (hist.size() > SS + FC) void'(hist.pop_back());
    {exp_dbg, exp_time, exp_irq} = core_n ? m_f : '0;
    exp_ipi = core_n & m_p;
    exp_cnt = core_n ? m_c : '0;
    flip = '1;
    for (int j = 0; j < FC; j++) begin
      h = (SS + j < hist.size()) ? hist[SS + j] : '0;
      flip &= h ^ m_f;
    end
    m_f ^= flip;
    if (set_i) begin
      if (clr_i) m_c = '0;
      else if (m_p && m_c != MAXC) m_c = m_c + 1'b1;
      m_p = 1'b1;
    end else if (clr_i) begin
      m_p = 1'b0;
      m_c = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {irq_o, time_irq_o, debug_req_o, ipi_o, ipi_cnt_o},
                   {exp_irq, exp_time, exp_dbg, exp_ipi, exp_cnt});
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst", {irq_o, time_irq_o, debug_req_o, ipi_o, ipi_cnt_o}, 0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd2};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0};

    rst_n = 1'b0; core_n = 1'b0; irq_a = '0; time_a = 1'b0; dbg_a = 1'b0;
    set_i = 1'b0; clr_i = 1'b0;
    model_clear();
    #3;
    check("reset_state", {irq_o, time_irq_o, debug_req_o, ipi_o, ipi_cnt_o}, 0);
    #9 rst_n = 1'b1;

    // Masked while core reset low, even with all lines asserted.
    irq_a = '1; time_a = 1'b1; dbg_a = 1'b1;
    repeat (50) step();
    check("mask_hold", {irq_o, time_irq_o, debug_req_o}, 0);
    core_n = 1'b1;
    step();
    check("unmask", {irq_o, time_irq_o, debug_req_o}, {2'b11, 1'b1, 1'b1});

    // IPI table.
    for (int i = 0; i < 12; i++) begin
      set_i = tbl[i].set; clr_i = tbl[i].clr;
      step();
      check($sformatf("ipi_tbl[%0d]", i), {ipi_o, ipi_cnt_o}, {tbl[i].exp_ipi, tbl[i].exp_cnt});
    end
    set_i = 1'b0; clr_i = 1'b0;

    // Glitch rejection then exact latency of a 4-cycle pulse.
    irq_a = '0; time_a = 1'b0; dbg_a = 1'b0;
    repeat (12) step();
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        irq_a[0] = (i < 3);
        step();
        seen |= irq_o[0];
      end
      check("glitch_3cyc", seen, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      irq_a[0] = (i < 4);
      step();
      if (i == 5) check("lat_before", irq_o[0], 1'b0);
      if (i == 6) check("lat_at7", irq_o[0], 1'b1);
    end
    repeat (12) step();

    // Saturation and clear latency.
    set_i = 1'b1;
    repeat (20) step();
    set_i = 1'b0;
    check("sat", {ipi_o, ipi_cnt_o}, {1'b1, 4'd15});
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_edge1", {ipi_o, ipi_cnt_o}, {1'b1, 4'd15});
    step();
    check("clr_edge2", {ipi_o, ipi_cnt_o}, 0);

    // Simultaneous set/clear with c=5.
    set_i = 1'b1;
    repeat (6) step();
    clr_i = 1'b1;
    step();
    set_i = 1'b0; clr_i = 1'b0;
    step();
    check("set_clr_same", {ipi_o, ipi_cnt_o}, {1'b1, 4'd0});
    clr_i = 1'b1; step(); clr_i = 1'b0; step();

    // IPI during core reset survives until release.
    core_n = 1'b0;
    set_i = 1'b1; step(); set_i = 1'b0;
    repeat (1000) step();
    check("early_masked", ipi_o, 1'b0);
    core_n = 1'b1;
    step();
    check("early_ipi", ipi_o, 1'b1);
    clr_i = 1'b1; step(); clr_i = 1'b0;

    // Mid-filter async reset restarts full latency.
    irq_a = '1; dbg_a = 1'b1; set_i = 1'b1; step(); set_i = 1'b0;
    repeat (10) step();
    time_a = 1'b1;
    repeat (4) step();
    async_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 5) check("rst_lat_before", time_irq_o, 1'b0);
      if (i == 6) check("rst_lat_at7", time_irq_o, 1'b1);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < NR; l++) if ($urandom_range(0, 9) == 0) irq_a[l] = ~irq_a[l];
      if ($urandom_range(0, 9) == 0) time_a = ~time_a;
      if ($urandom_range(0, 9) == 0) dbg_a = ~dbg_a;
      set_i = ($urandom_range(0, 3) == 0);
      clr_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) core_n = ~core_n;
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_conditioner.md
# irq_conditioner

Interrupt conditioning stage directly upstream of the OpenPiton core wrapper. It turns raw asynchronous interrupt and debug lines into clean, glitch-filtered, clock-domain-local levels for the wrapper's `irq_i`, `time_irq_i` and `debug_req_i` inputs. It latches single-cycle IPI pulses from the NoC return path into a sticky pending level for `ipi_i`. All outputs are held low until the core's synchronized reset (`spc_grst_l`) is released.

## Interface

Parameters:
- `NrIrq`, 2: number of external level interrupt lines (mip/sip).
- `SyncStages`, 2: flops per synchronizer chain, must be ≥2.
- `FilterCycles`, 4: consecutive stable cycles before a filtered level changes, must be ≥1 and ≤255.
- `CntWidth`, 4: width of the coalesced-IPI counter.

Ports:
- `clk_i`  in  1: core clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `core_rst_ni`  in  1: wrapper's synchronized core reset (`spc_grst_l`), synchronous to `clk_i`. Low masks all outputs.
- `irq_async_i`  in  NrIrq: raw level interrupts, asynchronous.
- `time_irq_async_i`  in  1: raw timer interrupt, asynchronous.
- `debug_req_async_i`  in  1: raw debug request, asynchronous.
- `ipi_set_i`  in  1: single-cycle synchronous IPI pulse from the L1.5 interrupt return.
- `ipi_clr_i`  in  1: synchronous IPI clear (MMIO/CSR write strobe).
- `irq_o`  out  NrIrq: conditioned interrupt levels.
- `time_irq_o`  out  1: conditioned timer interrupt.
- `debug_req_o`  out  1: conditioned debug request.
- `ipi_o`  out  1: IPI pending level.
- `ipi_cnt_o`  out  CntWidth: IPIs coalesced into the current pending level, saturating.

## Operation

- Async lines: `irq_async_i`, `time_irq_async_i` and `debug_req_async_i` form NrIrq+2 lanes. Each lane has the same pipeline:
  - A synchronizer chain of SyncStages flops, all resetting to 0. Its last-stage output is `s`.
  - A glitch filter holding filtered level `f` (reset 0) and counter `cnt` (8 bits, reset 0):
    - `s == f`: `cnt <= 0`.
    - `s != f` and `cnt == FilterCycles-1`: `f <= s`, `cnt <= 0`.
    - Otherwise: `cnt <= cnt+1`.
  - A pulse on `s` shorter than FilterCycles cycles never reaches `f`. The counter restarts whenever `s` returns to `f`.
- IPI pending register `p` (reset 0) and counter `c` (reset 0):
  - `ipi_set_i` only: `p <= 1`. If `p` was already 1, `c <= min(c+1, 2^CntWidth-1)`.
  - `ipi_clr_i` only: `p <= 0`, `c <= 0`.
  - Both in the same cycle: set wins. `p <= 1`, `c <= 0`.
  - Neither: hold.
- Output stage (registered, all reset 0): each output `<= core_rst_ni & level`. Level is `f` for the async lanes and `p` for `ipi_o`. `ipi_cnt_o <= core_rst_ni ? c : 0`.
- While `core_rst_ni` is low, the synchronizers, filters, `p` and `c` keep running. Only the outputs are masked. An IPI received during the wrapper's SRAM-init wait is therefore delivered once `core_rst_ni` rises.
- `rst_ni` assertion at any time asynchronously clears every flop, including synchronizers, counters, `p`, `c` and outputs. In-flight filter counts are discarded.

## Timing

- Async lane latency, from the first `clk_i` edge sampling a new stable input to the output change: SyncStages + FilterCycles + 1 cycles. With defaults this is 7.
- IPI latency: `ipi_set_i` high at edge N gives `p`=1 after edge N and `ipi_o`=1 after edge N+1. `ipi_clr_i` has the same latency to drop `ipi_o`.
- Unmask: `core_rst_ni` rising at edge N makes outputs reflect current levels after edge N+1. Falling masks them after edge N+1.
- No combinational path from any input to any output.
- Saturation: `c` stops at 2^CntWidth-1 (15 with defaults). Further sets do not wrap.

## Test plan

- Reset/mask:
  - Hold `core_rst_ni`=0 and drive all async inputs to 1 for 50 cycles: all outputs stay 0.
  - Raise `core_rst_ni`: `irq_o`=2'b11, `time_irq_o`=1 and `debug_req_o`=1 one cycle later.
- Glitch rejection: with defaults and `core_rst_ni`=1, pulse `irq_async_i[0]` high for 3 cycles: `irq_o[0]` never asserts. A 4-cycle-stable pulse asserts `irq_o[0]` exactly 7 cycles after the first sampling edge.
- IPI coalescing:
  - Pulse `ipi_set_i` 20 times with no clear: `ipi_o`=1 and `ipi_cnt_o` saturates at 15.
  - Pulse `ipi_clr_i`: `ipi_o`=0 and `ipi_cnt_o`=0 after 2 cycles.
- Simultaneous set/clear: with `p`=1 and `c`=5, assert `ipi_set_i` and `ipi_clr_i` together: `ipi_o` stays 1 and `ipi_cnt_o`=0.
- Early IPI: pulse `ipi_set_i` while `core_rst_ni`=0, then release 1000 cycles later: `ipi_o`=1 one cycle after release.
- Mid-operation reset: assert `rst_ni` low asynchronously mid-filter with `time_irq_async_i`=1 and `cnt`=2. All outputs go to 0 immediately. After release, the full 7-cycle latency (with `core_rst_ni`=1) is required again before `time_irq_o` asserts.
